// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl
// -----------------
// Bridges the CPU's byte-addressed, waitrequest-style memory port to a
// word-addressed mips_cpu_RAM with a one-cycle registered read.
//   - Reads take two cycles: address is issued, then data is returned.
//   - Full-word writes complete in one cycle.
//   - Partial writes use a read-modify-write and take two cycles.
//   - Requests that are misaligned or outside the RAM complete at once
//     with cpu_error and never touch the RAM.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   cpu_address         : CPU byte address
//   cpu_read/cpu_write  : CPU request strobes (both high = write + error)
//   cpu_byteenable      : write lane enables (bit i -> bits 8i+7:8i)
//   cpu_writedata       : CPU write data
//   cpu_readdata        : read data, non-zero only on a read completion
//   cpu_waitrequest     : high while the current request is not complete
//   cpu_error           : one-cycle pulse on a faulting completion
//   ram_address         : RAM word index (byte address >> 2)
//   ram_read/ram_write  : RAM strobes (never both in one cycle)
//   ram_writedata       : RAM write data
//   ram_readdata        : RAM read data, valid one cycle after the address
module mips_cpu_mem_ctrl #(
  parameter int RAM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        cpu_error,
  output logic [31:0] ram_address,
  output logic        ram_write,
  output logic        ram_read,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RMW  = 2'd2;

  localparam logic [31:0] RAM_WORDS_W = 32'(RAM_WORDS);

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        both_reg;
  logic        latch_en;

  logic [31:0] word_idx;
  logic        req;
  logic        fault;
  logic [31:0] merged;

  assign word_idx = {2'b00, cpu_address[31:2]};
  assign req      = cpu_read | cpu_write;
  assign fault    = (cpu_address[1:0] != 2'b00) || (word_idx >= RAM_WORDS_W);

  // Read-modify-write merge: enabled lanes come from the latched CPU data,
  // the rest from the word just read back from RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                            : ram_readdata[8*gi +: 8];
    end
  endgenerate

  // Outputs are decoded from state and the live request so that single-cycle
  // completions (full write, null write, fault) need no extra register stage.
  always_comb begin
    state_next      = state_reg;
    latch_en        = 1'b0;
    cpu_readdata    = 32'd0;
    cpu_waitrequest = 1'b0;
    cpu_error       = 1'b0;
    ram_address     = 32'd0;
    ram_read        = 1'b0;
    ram_write       = 1'b0;
    ram_writedata   = 32'd0;

    if (reset) begin
      // Hold the CPU off and keep the RAM quiet for the whole reset window,
      // which also aborts an in-flight RMW before its write is issued.
      cpu_waitrequest = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (fault) begin
              cpu_error = 1'b1;
            end else if (cpu_write) begin
              cpu_error = cpu_read;
              if (cpu_byteenable == 4'hF) begin
                ram_write     = 1'b1;
                ram_address   = word_idx;
                ram_writedata = cpu_writedata;
              end else if (cpu_byteenable != 4'h0) begin
                // Error (for read+write) is reported on the RMW completion.
                cpu_error       = 1'b0;
                ram_read        = 1'b1;
                ram_address     = word_idx;
                cpu_waitrequest = 1'b1;
                latch_en        = 1'b1;
                state_next      = RMW;
              end
            end else begin
              ram_read        = 1'b1;
              ram_address     = word_idx;
              cpu_waitrequest = 1'b1;
              latch_en        = 1'b1;
              state_next      = RD;
            end
          end
        end
        RD: begin
          ram_address  = addr_reg;
          cpu_readdata = ram_readdata;
          state_next   = IDLE;
        end
        RMW: begin
          ram_write     = 1'b1;
          ram_address   = addr_reg;
          ram_writedata = merged;
          cpu_error     = both_reg;
          state_next    = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      both_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        addr_reg  <= word_idx;
        wdata_reg <= cpu_writedata;
        be_reg    <= cpu_byteenable;
        both_reg  <= cpu_read & cpu_write;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Testbench for mips_cpu_mem_ctrl: a word-array RAM with registered read sits
// behind the DUT; a separate shadow memory predicts results from the
// request rules (fault / read / full, null and partial write).
module tb_mips_cpu_mem_ctrl;

  localparam int RW = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic        cpu_error;
  logic [31:0] ram_address;
  logic        ram_write;
  logic        ram_read;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  logic [31:0] mem     [0:RW-1];
  logic [31:0] ref_mem [0:RW-1];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_ctrl #(.RAM_WORDS(RW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_byteenable  (cpu_byteenable),
    .cpu_writedata   (cpu_writedata),
    .cpu_readdata    (cpu_readdata),
    .cpu_waitrequest (cpu_waitrequest),
    .cpu_error       (cpu_error),
    .ram_address     (ram_address),
    .ram_write       (ram_write),
    .ram_read        (ram_read),
    .ram_writedata   (ram_writedata),
    .ram_readdata    (ram_readdata)
  );

  // Downstream RAM: one-cycle registered read, preload port for the bench.
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (ram_write) mem[ram_address[11:0]] <= ram_writedata;
    ram_readdata <= mem[ram_address[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference behaviour of one request, from the request rules alone.
  task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       output int lat, output logic err, output logic [31:0] rdata,
                       output int nwr, output int nrd);
    int unsigned idx;
    idx   = addr >> 2;
    lat   = 1; err = 1'b0; rdata = 32'd0; nwr = 0; nrd = 0;
    if (addr[1:0] != 2'b00 || idx >= RW) begin
      err = 1'b1;
    end else if (wr) begin
      err = rd;
      if (be == 4'hF) begin
        ref_mem[idx] = wdata;
        nwr = 1;
      end else if (be != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        lat = 2; nwr = 1; nrd = 1;
      end
    end else begin
      lat = 2; nrd = 1; rdata = ref_mem[idx];
    end
  endtask

  // Present a request, wait (bounded) for completion, and collect what the
  // DUT did. bad flags protocol errors in the waiting cycles.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output int nwr, output int nrd, output logic bad);
    cpu_read = rd; cpu_write = wr; cpu_address = addr;
    cpu_byteenable = be; cpu_writedata = wdata;
    lat = 0; err = 1'b0; rdata = 32'd0; nwr = 0; nrd = 0; bad = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      nwr += int'(ram_write);
      nrd += int'(ram_read);
      if (ram_read && ram_write) bad = 1'b1;
      if (!cpu_waitrequest) begin
        lat = c; err = cpu_error; rdata = cpu_readdata;
        break;
      end else if (cpu_readdata != 32'd0 || cpu_error) begin
        bad = 1'b1;
      end
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
    int lat, e_lat, nwr, e_nwr, nrd, e_nrd;
    logic err, e_err, bad;
    logic [31:0] rdata, e_rdata;
    model(rd, wr, addr, be, wdata, e_lat, e_err, e_rdata, e_nwr, e_nrd);
    do_req(rd, wr, addr, be, wdata, lat, err, rdata, nwr, nrd, bad);
    $display("txn %s rd=%0d wr=%0d addr=%h be=%h wdata=%h -> lat=%0d err=%0d rdata=%h ram_wr=%0d ram_rd=%0d",
             tag, rd, wr, addr, be, wdata, lat, err, rdata, nwr, nrd);
    check({tag, ".latency"},  32'(lat), 32'(e_lat));
    check({tag, ".error"},    32'(err), 32'(e_err));
    check({tag, ".readdata"}, rdata, e_rdata);
    check({tag, ".ram_write_count"}, 32'(nwr), 32'(e_nwr));
    check({tag, ".ram_read_count"},  32'(nrd), 32'(e_nrd));
    check({tag, ".protocol"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] v, a;
    logic [3:0]  be;
    logic        rd, wr;

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h14;
    cpu_byteenable = 4'h0; cpu_writedata = 32'd0;
    @(posedge clk); #1;

    // Preload random contents while the DUT sits in reset with a pending read.
    for (int i = 0; i < RW; i++) begin
      v = $urandom;
      if (i == 5) v = 32'h11223344;
      load_en = 1'b1; load_addr = 12'(i); load_data = v;
      ref_mem[i] = v;
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    @(negedge clk);
    check("reset.waitrequest", 32'(cpu_waitrequest), 32'd1);
    check("reset.ram_read",    32'(ram_read),        32'd0);
    check("reset.ram_write",   32'(ram_write),       32'd0);
    check("reset.error",       32'(cpu_error),       32'd0);
    check("reset.readdata",    cpu_readdata,         32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    check("idle.waitrequest", 32'(cpu_waitrequest), 32'd0);
    @(posedge clk); #1;

    run_req("read_word5",   1'b1, 1'b0, 32'h14, 4'h0, 32'd0);
    run_req("full_write20", 1'b0, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
    run_req("read20",       1'b1, 1'b0, 32'h20, 4'h0, 32'd0);
    run_req("part_write20", 1'b0, 1'b1, 32'h20, 4'b0001, 32'h000000AA);
    run_req("read20b",      1'b1, 1'b0, 32'h20, 4'h0, 32'd0);
    check("word8_value", ref_mem[8], 32'hDEADBEAA);
    run_req("misaligned",   1'b1, 1'b0, 32'h22, 4'h0, 32'd0);
    run_req("out_of_range", 1'b1, 1'b0, 32'h4000, 4'h0, 32'd0);
    run_req("last_word",    1'b1, 1'b0, 32'h3FFC, 4'h0, 32'd0);
    run_req("null_write",   1'b0, 1'b1, 32'h24, 4'h0, 32'h12345678);
    run_req("both_full",    1'b1, 1'b1, 32'h28, 4'hF, 32'hCAFEF00D);
    run_req("both_part",    1'b1, 1'b1, 32'h28, 4'b0110, 32'h00ABCD00);

    // Reset arriving during the RMW cycle must suppress the write.
    cpu_write = 1'b1; cpu_address = 32'h30; cpu_byteenable = 4'b1000;
    cpu_writedata = 32'hFF000000;
    @(negedge clk);
    check("abort.accept_wait", 32'(cpu_waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort.ram_write",   32'(ram_write),       32'd0);
    check("abort.waitrequest", 32'(cpu_waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    check("abort.idle_after", 32'(cpu_waitrequest), 32'd0);
    @(posedge clk); #1;
    run_req("read30_after_abort", 1'b1, 1'b0, 32'h30, 4'h0, 32'd0);

    // Write immediately followed by a read of the same word.
    run_req("b2b_write40", 1'b0, 1'b1, 32'h40, 4'hF, 32'h5A5AA5A5);
    run_req("b2b_read40",  1'b1, 1'b0, 32'h40, 4'h0, 32'd0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       a = ($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
        1:       a = 32'($urandom_range(RW, RW + 100)) << 2;
        2:       a = 32'(RW - 1) << 2;
        default: a = 32'($urandom_range(0, 31)) << 2;
      endcase
      case ($urandom_range(0, 5))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        5:       begin rd = 1'b1; wr = 1'b1; end
        default: begin rd = 1'b0; wr = 1'b1; end
      endcase
      case ($urandom_range(0, 3))
        0:       be = 4'hF;
        1:       be = 4'h0;
        default: be = 4'($urandom_range(0, 15));
      endcase
      run_req($sformatf("rand%0d", n), rd, wr, a, be, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_ctrl.md
MIPS_CPU_MEM_CTRL -- requirements
Module: mips_cpu_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, the number of 32-bit words in the downstream mips_cpu_RAM.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on posedge clk.
REQ-004 SHALL have port cpu_address, input, 32, CPU byte address.
REQ-005 SHALL have port cpu_read, input, 1, CPU read request.
REQ-006 SHALL have port cpu_write, input, 1, CPU write request.
REQ-007 SHALL have port cpu_byteenable, input, 4, write lane enables; bit i qualifies cpu_writedata[8i+7:8i].
REQ-008 SHALL have port cpu_writedata, input, 32, CPU write data.
REQ-009 SHALL have port cpu_readdata, output, 32, read data, valid in the cycle a read completes.
REQ-010 SHALL have port cpu_waitrequest, output, 1, high = request not yet complete; CPU holds request.
REQ-011 SHALL have port cpu_error, output, 1, one-cycle pulse on the completion cycle of a faulting request.
REQ-012 SHALL have port ram_address, output, 32, RAM word index (byte address >> 2, zero-extended).
REQ-013 SHALL have port ram_write, output, 1, RAM write strobe.
REQ-014 SHALL have port ram_read, output, 1, RAM read strobe.
REQ-015 SHALL have port ram_writedata, output, 32, RAM write data.
REQ-016 SHALL have port ram_readdata, input, 32, RAM read data, valid one cycle after ram_address is presented.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RMW; only IDLE accepts new requests.
REQ-018 SHALL complete a request in the cycle cpu_waitrequest is low while cpu_read or cpu_write is high.
REQ-019 SHALL drive cpu_waitrequest low in IDLE when no request is present.
REQ-020 SHALL treat a request as faulting when cpu_address[1:0] != 0 or cpu_address[31:2] >= RAM_WORDS: no RAM strobe, complete in IDLE the same cycle, cpu_readdata = 0, cpu_error = 1.
REQ-021 SHALL treat cpu_read and cpu_write both high as a write, with cpu_error pulsed on completion.
REQ-022 Read: IDLE -> assert ram_read with ram_address = cpu_address[31:2], waitrequest = 1, go RD; RD -> cpu_readdata = ram_readdata, waitrequest = 0, go IDLE (latency 2 cycles).
REQ-023 Full write (byteenable = 4'hF): in IDLE assert ram_write with ram_writedata = cpu_writedata, waitrequest = 0, stay IDLE (latency 1 cycle).
REQ-024 Null write (byteenable = 4'h0): no RAM strobe, waitrequest = 0, complete in IDLE, no error.
REQ-025 Partial write: IDLE -> assert ram_read, latch word index, byteenable and writedata, waitrequest = 1, go RMW; RMW -> ram_write with each lane = latched writedata lane if its enable bit is set, else ram_readdata lane; waitrequest = 0; go IDLE.
REQ-026 SHALL drive RAM address and data in RD/RMW from latched copies; CPU input changes during those states SHALL be ignored.
REQ-027 SHALL never assert ram_read and ram_write in the same cycle, and SHALL issue at most one RAM write per request.
REQ-028 Back-to-back: a request present in the same cycle the FSM returns to IDLE SHALL be accepted on the following cycle.
REQ-029 cpu_readdata SHALL be 0 in every cycle that is not a read completion.

Reset
REQ-030 While reset is high: state -> IDLE, ram_read = 0, ram_write = 0, cpu_waitrequest = 1, cpu_error = 0, cpu_readdata = 0, latches cleared.
REQ-031 Reset asserted in RD or RMW SHALL abort the request with no RAM write issued; the first cycle after reset deasserts SHALL be IDLE.

Verification
REQ-032 RAM word 5 = 0x11223344, read cpu_address 0x14 -> waitrequest high 1 cycle, then cpu_readdata = 0x11223344, error 0.
REQ-033 Write 0xDEADBEEF, byteenable 4'hF, address 0x20 -> single-cycle completion; subsequent read of 0x20 returns 0xDEADBEEF.
REQ-034 Word 8 = 0xDEADBEEF, write 0x000000AA, byteenable 4'b0001, address 0x20 -> 2-cycle completion; word 8 = 0xDEADBEAA; exactly one ram_write pulse.
REQ-035 Read address 0x22, then read address 0x4000 (RAM_WORDS = 4096) -> each completes in 1 cycle, cpu_readdata 0, cpu_error pulsed, no ram_read or ram_write.
REQ-036 Partial write 0xFF000000, byteenable 4'b1000, address 0x30, reset asserted in RMW cycle -> no ram_write; word 12 unchanged; IDLE after reset deasserts.
REQ-037 Full write to 0x40 followed immediately by read of 0x40 -> read returns the newly written data in the RD cycle.
